if_id_stage_buf: RTL and testbench
==================================

Name: if_id_stage_buf

Overview:
- Parametrised IF/ID pipeline stage for the processor front end. Carries PC and instruction from fetch to decode.
- Adds a valid/ready handshake, stall back-pressure and flush (branch/jump squash) on top of the plain clocked pipeline register.
- Built as a 2-entry skid buffer, so `in_ready` is a pure register output and no combinational path runs from `out_ready` to `in_ready`.
- Sits between the instruction memory/PC logic and the decode stage.

Parameters:
- PC_W, 8, width of PC field
- INSTR_W, 32, width of instruction field
- NOP_INSTR, 32'h0000_0000, value driven on out_instr when the stage is empty or flushed
- CNT_W, 16, width of performance counters (used only with IF_ID_PERF_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents a valid PC/instruction
- in_ready  out  1  stage can accept a beat this cycle (registered)
- in_pc  in  PC_W  incremented PC from fetch
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts the beat this cycle
- out_pc  out  PC_W  PC presented to decode
- out_instr  out  INSTR_W  instruction presented to decode
- flush  in  1  squash all held and incoming beats
- occupancy  out  2  number of held beats, 0..2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (IF_ID_PERF_EN only)
- flush_cnt  out  CNT_W  flush cycles that discarded at least one valid beat (IF_ID_PERF_EN only)

Behaviour:
- Storage is a main register (drives the outputs) plus a skid register, each with its own valid bit.
- State follows occupancy: EMPTY (0), ONE (main valid), FULL (main+skid valid).
- Reset (rst=1 at a clock edge), regardless of state:
  - both valid bits = 0; out_valid=0; in_ready=1; occupancy=0
  - out_pc=0; out_instr=NOP_INSTR; counters=0
  - A reset mid-transfer drops every held beat without handshake.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - Data is held stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input acceptance to out_valid in EMPTY (same as a plain pipeline register). Throughput is 1 beat/cycle in ONE with out_ready=1.
- Transitions (no flush):
  - EMPTY + accept -> ONE; main loads input.
  - ONE + accept + consume -> ONE; main loads input.
  - ONE + accept, no consume -> FULL; skid loads input.
  - ONE + consume, no accept -> EMPTY.
  - FULL + consume -> ONE; main loads skid. No accept is possible because in_ready=0.
  - FULL, no consume -> FULL; hold.
- in_ready is registered: it is 1 in the cycle after the state is EMPTY or ONE, and 0 in FULL.
- Order is preserved: the skid beat is always older than any later input.
- Flush (flush=1 at an edge):
  - both valid bits cleared; next state EMPTY
  - an input accepted in the same cycle is discarded (flush wins)
  - a beat consumed by decode in the same cycle is treated as delivered
  - out_instr=NOP_INSTR and out_pc holds its last value until the next load
  - in_ready=1 on the next cycle
- When empty, out_instr=NOP_INSTR, so decode sees a bubble even if it ignores out_valid.
- Simultaneous rst and flush: rst dominates.

Optional Feature:
- IF_ID_PERF_EN defined:
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - flush_cnt increments on each flush cycle where occupancy>0 or an input was accepted.
  - Both saturate at all-ones; no wrap-around.
- IF_ID_PERF_EN undefined: the counter logic is not compiled; stall_cnt and flush_cnt are tied to 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2
  - the default NOP_INSTR
  - a packed if_id_beat_t {pc, instr} so the main and skid registers use one type
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, clr, count), instantiated twice under IF_ID_PERF_EN.

Test Plan:
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR, occupancy=0.
- Streaming: out_ready=1, send pc 0x04,0x08,0x0C with instrs 0xA1..0xA3 back-to-back -> each appears 1 cycle later, in order, no bubbles, in_ready stays 1.
- Back-pressure: out_ready=0, send 0x10 and 0x14 -> occupancy=2, in_ready=0 the next cycle, out_pc held at 0x10. Then raise out_ready -> 0x10 then 0x14 delivered, nothing lost or duplicated.
- Flush: in FULL, assert flush together with in_valid (pc 0x20) -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, in_ready=1, and 0x20 is never output.
- Reset mid-operation: in FULL, pulse rst -> all valids cleared; the first beat after reset (pc 0x30) is output alone.
- IF_ID_PERF_EN with CNT_W=4: hold out_ready=0 with valid data for 20 cycles -> stall_cnt=15 (saturated). One flush with data held -> flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared definitions for the IF/ID front-end pipeline stage:
//            occupancy encoding, default bubble instruction, beat type.
//            Optional feature macro used by consumers: IF_ID_PERF_EN
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy encoding; the stage FSM uses these values directly so the
  // state register doubles as the occupancy output.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Default field widths and the bubble instruction placed on decode's input.
  localparam int          C_PC_W      = 8;
  localparam int          C_INSTR_W   = 32;
  localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } if_id_state_t;

  // One fetched beat at the default widths.
  typedef struct packed {
    logic [C_PC_W-1:0]    pc;
    logic [C_INSTR_W-1:0] instr;
  } if_id_beat_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
//            Instantiated by if_id_stage_buf only with IF_ID_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter import pipe_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count qualified events, holding at the maximum value once reached.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_id_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage_buf
// Brief    : IF/ID pipeline stage built as a 2-entry skid buffer with
//            valid/ready handshake, stall back-pressure and flush.
//            in_ready is registered, so out_ready never reaches it
//            combinationally.
//            Optional feature macro: IF_ID_PERF_EN (stall/flush counters)
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage_buf import pipe_pkg::*; #(
  parameter int                 PC_W      = C_PC_W,
  parameter int                 INSTR_W   = C_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(C_NOP_INSTR),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Same layout as if_id_beat_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  // The state is the pair of valid bits: main valid in ONE/FULL, skid valid
  // only in FULL. The skid entry is always the older of the two once main drains.
  if_id_state_t r_state;
  if_id_state_t w_state_nxt;
  beat_t        r_main;
  beat_t        r_skid;
  beat_t        w_in_beat;
  beat_t        w_main_nxt;
  logic         r_in_ready;
  logic         w_load_main;
  logic         w_load_skid;
  logic         w_main_vld;
  logic         w_accept;
  logic         w_consume;

  assign w_in_beat  = '{pc: in_pc, instr: in_instr};
  assign w_main_vld = (r_state != ST_EMPTY);
  assign w_accept   = in_valid & r_in_ready;
  assign w_consume  = w_main_vld & out_ready;

  // State register plus the registered form of in_ready derived from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Next-state and register load selection; flush overrides every load.
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_main_nxt  = w_in_beat;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_consume) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_consume) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  // Beat storage; out_pc keeps its last value across a flush until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '{pc: '0, instr: NOP_INSTR};
      r_skid <= '{pc: '0, instr: NOP_INSTR};
    end else begin
      if (w_load_main) r_main <= w_main_nxt;
      if (w_load_skid) r_skid <= w_in_beat;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_vld;
  assign out_pc    = r_main.pc;
  assign out_instr = w_main_vld ? r_main.instr : NOP_INSTR;
  assign occupancy = r_state;

`ifdef IF_ID_PERF_EN
  logic w_stall_evt;
  logic w_flush_evt;

  // A flush is counted only when it actually discarded a beat.
  assign w_stall_evt = w_main_vld & ~out_ready;
  assign w_flush_evt = flush & (w_main_vld | w_accept);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_evt),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_evt),
    .clr   (1'b0),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage_buf
// Brief    : Scoreboard bench for if_id_stage_buf. Directed stimulus pushes
//            expected beats; a negedge monitor pops and compares each beat
//            decode consumes. Counter checks depend on IF_ID_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage_buf;

  localparam int          PC_W    = 8;
  localparam int          INSTR_W = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  if_id_stage_buf #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and record it as expected output.
  task automatic send(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
    sb.push_back('{pc: pc, instr: instr});
  endtask

  // Monitor: every consumed beat must match the head of the scoreboard;
  // an idle stage must show the bubble instruction.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got pc 0x%0h, expected no beat", out_pc);
        end else begin
          e = sb.pop_front();
          chk("beat_pc", 64'(out_pc), 64'(e.pc));
          chk("beat_instr", 64'(out_instr), 64'(e.instr));
        end
      end
      if (out_valid !== 1'b1) chk("bubble_nop", 64'(out_instr), 64'(NOP));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with a valid input present.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 8'hFF; in_instr = 32'hDEAD_BEEF;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    mon_en = 1'b1;

    // Streaming at full rate.
    rst = 1'b0; out_ready = 1'b1;
    send(8'h04, 32'h0000_00A1); tick();
    chk("str1_valid", 64'(out_valid), 64'd1);
    chk("str1_pc",    64'(out_pc),    64'h04);
    chk("str1_ready", 64'(in_ready),  64'd1);
    send(8'h08, 32'h0000_00A2); tick();
    chk("str2_pc",    64'(out_pc),    64'h08);
    chk("str2_ready", 64'(in_ready),  64'd1);
    send(8'h0C, 32'h0000_00A3); tick();
    chk("str3_pc",    64'(out_pc),    64'h0C);
    chk("str3_occ",   64'(occupancy), 64'd1);
    in_valid = 1'b0; tick();
    chk("str_drain_valid", 64'(out_valid), 64'd0);
    chk("str_drain_occ",   64'(occupancy), 64'd0);

    // Back-pressure fills the skid entry.
    out_ready = 1'b0;
    send(8'h10, 32'h0000_00B1); tick();
    send(8'h14, 32'h0000_00B2); tick();
    in_valid = 1'b0;
    chk("bp_occ",      64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready),  64'd0);
    chk("bp_pc",       64'(out_pc),    64'h10);
    tick();
    chk("bp_hold_pc",  64'(out_pc),    64'h10);
    chk("bp_hold_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1; tick();
    chk("bp_drain1_pc",  64'(out_pc),    64'h14);
    chk("bp_drain1_occ", 64'(occupancy), 64'd1);
    chk("bp_drain1_rdy", 64'(in_ready),  64'd1);
    tick();
    chk("bp_drain2_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Flush while FULL, with a new input offered in the same cycle.
    send(8'h18, 32'h0000_00C1); tick();
    send(8'h1C, 32'h0000_00C2); tick();
    flush = 1'b1; in_valid = 1'b1; in_pc = 8'h20; in_instr = 32'h0000_00C3;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ",       64'(occupancy), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_instr", 64'(out_instr), 64'(NOP));
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    chk("fl_out_pc",    64'(out_pc),    64'h18);
    out_ready = 1'b1; tick(); tick(); tick();
    chk("fl_idle_occ",  64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Flush in ONE discards an input that is accepted the same cycle.
    send(8'h24, 32'h0000_00D1); tick();
    flush = 1'b1; in_pc = 8'h28; in_instr = 32'h0000_00D2;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_occ",    64'(occupancy), 64'd0);
    chk("fl1_valid",  64'(out_valid), 64'd0);
    chk("fl1_out_pc", 64'(out_pc),    64'h24);
    out_ready = 1'b1; tick(); tick();
    chk("fl1_idle_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset while FULL drops everything; next beat comes out alone.
    send(8'h40, 32'h0000_00E1); tick();
    send(8'h44, 32'h0000_00E2); tick();
    in_valid = 1'b0; rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("mr_occ",       64'(occupancy), 64'd0);
    chk("mr_in_ready",  64'(in_ready),  64'd1);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_pc",    64'(out_pc),    64'd0);
    out_ready = 1'b1;
    send(8'h30, 32'h0000_00F1); tick();
    in_valid = 1'b0;
    chk("mr_first_pc",    64'(out_pc),    64'h30);
    chk("mr_first_valid", 64'(out_valid), 64'd1);
    tick();
    chk("mr_after_valid", 64'(out_valid), 64'd0);
    tick();

    // Performance counters: stall saturation and a single counted flush.
    rst = 1'b1; out_ready = 1'b0; tick(); rst = 1'b0;
    chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
    chk("perf_rst_flush", 64'(flush_cnt), 64'd0);
    send(8'h50, 32'h0000_0051); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
`ifdef IF_ID_PERF_EN
    chk("perf_stall_sat", 64'(stall_cnt), 64'd15);
    chk("perf_flush_one", 64'(flush_cnt), 64'd1);
`else
    chk("perf_stall_off", 64'(stall_cnt), 64'd0);
    chk("perf_flush_off", 64'(flush_cnt), 64'd0);
`endif
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
